bcd_bin_seq: RTL and testbench

Parametrised sequential BCD-to-binary converter; successor to the combinational 3-digit converter.
- Accepts a DIGITS-digit packed BCD word on a start strobe and converts it one digit per clock (multiply-by-10 accumulate, MSD first).
- Reports the result with a busy/done handshake.
- Sits between BCD keypad/display front-ends and binary datapath logic.

---
 rtl/bcd_bin_seq.sv | 125 ++++++++++++
 tb/tb_bcd_bin_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_bin_seq.sv
// bcd_bin_seq: sequential BCD-to-binary converter.
// Takes a DIGITS-digit packed BCD word on a start strobe. It folds one digit per clock,
// most significant digit first, using acc = acc*10 + digit, and reports the result
// through a busy/done handshake.
// Optional macro BCD_BIN_DIGIT_CHECK_EN: a nibble above 9 is flagged on err and
// forces bin to 0. With the macro undefined, err is tied low and no checking
// logic is built.
module bcd_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    // Width of the digit counter. It is at least one bit so that DIGITS=1 still works.
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    logic [0:0]          state_reg;
    logic [4*DIGITS-1:0] shift_reg;
    logic [4*DIGITS-1:0] shift_next;
    logic [BIN_W-1:0]    acc_reg;
    logic [BIN_W-1:0]    acc_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [BIN_W-1:0]    bin_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [3:0]          nib;

    // The digit being folded in this cycle is always the top nibble of the shift register.
    assign nib = shift_reg[4*DIGITS-1 -: 4];

    // Multiply by 10 as x*8 + x*2. The sum is truncated modulo 2^BIN_W.
    assign acc_next = (acc_reg << 3) + (acc_reg << 1) + {{(BIN_W-4){1'b0}}, nib};

    // Shift left by one nibble. A zero nibble enters at the bottom.
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_shift
            assign shift_next[4*gi +: 4] = shift_reg[4*(gi-1) +: 4];
        end
    endgenerate
    assign shift_next[3:0] = 4'h0;

`ifdef BCD_BIN_DIGIT_CHECK_EN
    logic flag_reg;
    logic err_reg;
    logic bad_any;

    // The sticky flag, combined with the nibble in the current cycle. This covers the last digit too.
    assign bad_any = flag_reg | (nib > 4'd9);
    assign err     = err_reg;

    // Invalid-digit tracking: cleared on an accepted start, reported on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (st) flag_reg <= 1'b0;
        end else begin
            flag_reg <= bad_any;
            if (cnt_reg == '0) err_reg <= bad_any;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Control FSM and datapath: accept in IDLE, then fold one digit per clock in CONV.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            shift_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            bin_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (st) begin
                        shift_reg <= bcd;
                        acc_reg   <= '0;
                        cnt_reg   <= CNT_LAST;
                        busy_reg  <= 1'b1;
                        state_reg <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc_reg   <= acc_next;
                    shift_reg <= shift_next;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
`ifdef BCD_BIN_DIGIT_CHECK_EN
                        bin_reg <= bad_any ? '0 : acc_next;
`else
                        bin_reg <= acc_next;
`endif
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bin  = bin_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Testbench for bcd_bin_seq. Two DUT instances are used: a 3-digit/10-bit one and a 4-digit/14-bit one.
// Expected results come from a weighted-sum reference (sum of d_i * 10^i, modulo 2^BIN_W).
module tb_bcd_bin_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        st3, st4;
    logic [11:0] bcd3;
    logic [15:0] bcd4;
    logic [9:0]  bin3;
    logic [13:0] bin4;
    logic        busy3, done3, err3;
    logic        busy4, done4, err4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk(clk), .rst(rst), .st(st3), .bcd(bcd3),
        .bin(bin3), .busy(busy3), .done(done3), .err(err3)
    );

    bcd_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut4 (
        .clk(clk), .rst(rst), .st(st4), .bcd(bcd4),
        .bin(bin4), .busy(busy4), .done(done4), .err(err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the positional value of the BCD word, wrapped to the result width.
    function automatic void ref_conv(input logic [31:0] val, input int nd, input int w,
                                     output logic [31:0] eb, output logic ee);
        longint sum = 0;
        longint p   = 1;
        ee = 1'b0;
        for (int i = 0; i < nd; i++) begin
            longint d = longint'((val >> (4*i)) & 32'hF);
            if (d > 9) ee = 1'b1;
            sum += d * p;
            p   *= 10;
        end
        eb = 32'(sum % (64'd1 << w));
`ifdef BCD_BIN_DIGIT_CHECK_EN
        if (ee) eb = 0;
`else
        ee = 1'b0;
`endif
    endfunction

    // Runs one conversion on the selected DUT (0 = 3-digit, 1 = 4-digit) and checks the handshake.
    // If poke is set, start is pulsed on every busy cycle; those pulses must be ignored.
    task automatic run_conv(input int sel, input logic [31:0] val, input bit poke);
        int          nd = (sel != 0) ? 4 : 3;
        logic [31:0] eb;
        logic        ee;
        ref_conv(val, nd, (sel != 0) ? 14 : 10, eb, ee);
        if (sel != 0) begin bcd4 = val[15:0]; st4 = 1'b1; end
        else          begin bcd3 = val[11:0]; st3 = 1'b1; end
        @(posedge clk); #1;
        st3 = 1'b0; st4 = 1'b0;
        // Scramble the input after acceptance. The conversion in flight must not see it.
        bcd3 = 12'($urandom); bcd4 = 16'($urandom);
        for (int k = 0; k < nd; k++) begin
            check("busy_during", (sel != 0) ? busy4 : busy3, 1'b1);
            check("done_during", (sel != 0) ? done4 : done3, 1'b0);
            if (poke) begin
                if (sel != 0) st4 = 1'b1; else st3 = 1'b1;
            end
            @(posedge clk); #1;
            st3 = 1'b0; st4 = 1'b0;
        end
        check("done_pulse", (sel != 0) ? done4 : done3, 1'b1);
        check("busy_at_done", (sel != 0) ? busy4 : busy3, 1'b0);
        check("bin", (sel != 0) ? 32'(bin4) : 32'(bin3), eb);
        check("err", (sel != 0) ? err4 : err3, ee);
        $display("conv dut%0d bcd=%h exp_bin=%0h exp_err=%0b", nd, val, eb, ee);
        @(posedge clk); #1;
        check("done_single", (sel != 0) ? done4 : done3, 1'b0);
        check("bin_hold", (sel != 0) ? 32'(bin4) : 32'(bin3), eb);
    endtask

    initial begin
        logic [31:0] exp_seq [2];
        logic [31:0] v;
        exp_seq[0] = 32'h275;
        exp_seq[1] = 32'h3D6;

        rst = 1'b1; st3 = 1'b0; st4 = 1'b0; bcd3 = '0; bcd4 = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_bin", 32'(bin3), 0);
        check("rst_busy", busy3, 1'b0);
        check("rst_done", done3, 1'b0);
        check("rst_err", err3, 1'b0);
        check("rst_bin4", 32'(bin4), 0);
        rst = 1'b0;

        // Basic single conversion
        run_conv(0, 32'h227, 1'b0);

        // Back-to-back with start held high
        st3 = 1'b1; bcd3 = 12'h629;
        @(posedge clk); #1;
        for (int j = 0; j < 2; j++) begin
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk); #1;
                if (k < 3) begin
                    check("b2b_busy", busy3, 1'b1);
                    check("b2b_done", done3, 1'b0);
                end else begin
                    check("b2b_done_pulse", done3, 1'b1);
                    check("b2b_bin", 32'(bin3), exp_seq[j]);
                    $display("conv b2b bcd=%h exp_bin=%0h", (j == 0) ? 12'h629 : 12'h982, exp_seq[j]);
                    bcd3 = 12'h982;
                end
            end
            if (j == 0) begin
                @(posedge clk); #1;
                check("b2b_restart_busy", busy3, 1'b1);
                check("b2b_restart_done", done3, 1'b0);
                check("b2b_bin_stable", 32'(bin3), 32'h275);
            end
        end
        st3 = 1'b0;
        @(posedge clk); #1;
        check("b2b_tail_done", done3, 1'b0);
        check("b2b_tail_bin", 32'(bin3), 32'h3D6);

        // Idle with start low: nothing moves
        bcd3 = 12'h331;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_busy", busy3, 1'b0);
            check("idle_done", done3, 1'b0);
            check("idle_bin", 32'(bin3), 32'h3D6);
        end

        // Start pulses while busy are ignored
        run_conv(0, 32'h629, 1'b1);

        // Invalid digit
        run_conv(0, 32'h2A7, 1'b0);

        // Wider instance: maximum value and zero
        run_conv(1, 32'h9999, 1'b0);
        run_conv(1, 32'h0000, 1'b0);

        // Reset in the middle of a conversion
        bcd3 = 12'h982; st3 = 1'b1;
        @(posedge clk); #1;
        st3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", busy3, 1'b0);
        check("mid_rst_done", done3, 1'b0);
        check("mid_rst_bin", 32'(bin3), 0);
        check("mid_rst_err", err3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_done", done3, 1'b0);
        end
        run_conv(0, 32'h227, 1'b0);

        // Randomized conversions, mostly valid digits with occasional raw nibbles
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) v = 32'($urandom) & 32'hFFF;
            else v = {20'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_conv(0, v, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) v = 32'($urandom) & 32'hFFFF;
            else v = {16'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_conv(1, v, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
